// File: rtl/dcache_pkg.sv
// Shared types and address-split helpers for the direct-mapped data cache.
// Helpers take field widths as arguments so any cache geometry can use them.
package dcache_pkg;

  typedef enum logic [1:0] {
    DC_IDLE      = 2'd0,
    DC_WRITEBACK = 2'd1,
    DC_REFILL    = 2'd2
  } dcache_state_e;

  function automatic logic [31:0] get_offset(input logic [31:0] addr, input int offs_w);
    return addr & ((32'd1 << offs_w) - 32'd1);
  endfunction

  function automatic logic [31:0] get_index(input logic [31:0] addr, input int index_w,
                                            input int offs_w);
    return (addr >> offs_w) & ((32'd1 << index_w) - 32'd1);
  endfunction

  function automatic logic [31:0] get_tag(input logic [31:0] addr, input int index_w,
                                          input int offs_w);
    return addr >> (index_w + offs_w);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: asynchronous read by index, synchronous writes.
// Only valid/dirty are reset; tag and data are don't-care until a line is filled.
module dcache_array #(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 24,
  localparam int INDEX_W   = $clog2(NUM_LINES),
  localparam int OFFS_W    = $clog2(LINE_WORDS),
  localparam int LINE_W    = 32 * LINE_WORDS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INDEX_W-1:0] index,
  input  logic [OFFS_W-1:0]  offset,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [LINE_W-1:0]  rd_line,
  input  logic               fill_en,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic [LINE_W-1:0]  fill_line,
  input  logic               word_en,
  input  logic [31:0]        word_data,
  input  logic               clean_en
);

  logic [LINE_W-1:0]    data_q [NUM_LINES];
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;

  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_tag   = tag_q[index];
  assign rd_line  = data_q[index];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (word_en) begin
      dirty_q[index] <= 1'b1;
    end else if (clean_en) begin
      dirty_q[index] <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (fill_en) begin
      data_q[index] <= fill_line;
      tag_q[index]  <= fill_tag;
    end else if (word_en) begin
      data_q[index][int'(offset)*32 +: 32] <= word_data;
    end
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back, write-allocate data cache with writeback/refill FSM.
// Define DCACHE_STATS_EN to add the hit_count/miss_count statistics ports.
module dcache
  import dcache_pkg::*;
#(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 30,
  localparam int INDEX_W   = $clog2(NUM_LINES),
  localparam int OFFS_W    = $clog2(LINE_WORDS),
  localparam int TAG_W     = ADDR_W - INDEX_W - OFFS_W,
  localparam int LINE_W    = 32 * LINE_WORDS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [31:0]       wdata_in,
  output logic [31:0]       data_out,
  output logic              data_out_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_valid,
`ifdef DCACHE_STATS_EN
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
`endif
  output dcache_state_e     dbg_state
);

  logic [TAG_W-1:0]   tag;
  logic [INDEX_W-1:0] idx;
  logic [OFFS_W-1:0]  offs;

  assign tag  = TAG_W'(get_tag(32'(addr_in), INDEX_W, OFFS_W));
  assign idx  = INDEX_W'(get_index(32'(addr_in), INDEX_W, OFFS_W));
  assign offs = OFFS_W'(get_offset(32'(addr_in), OFFS_W));

  dcache_state_e     state, state_next;
  logic              rd_valid, rd_dirty;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic              fill_en, word_en, clean_en;
  logic              hit, req;

  dcache_array #(
    .NUM_LINES (NUM_LINES),
    .LINE_WORDS(LINE_WORDS),
    .TAG_W     (TAG_W)
  ) u_array (
    .clock    (clock),
    .reset    (reset),
    .index    (idx),
    .offset   (offs),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .fill_en  (fill_en),
    .fill_tag (tag),
    .fill_line(mem_rdata),
    .word_en  (word_en),
    .word_data(wdata_in),
    .clean_en (clean_en)
  );

  assign req       = req_rd | req_wr;
  assign hit       = (state == DC_IDLE) && rd_valid && (rd_tag == tag);
  assign dbg_state = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= DC_IDLE;
    else        state <= state_next;
  end

  // mem_req/mem_valid handshake: mem_req stays high for the whole transfer and
  // drops at the edge after the one-cycle mem_valid pulse that completes it.
  always_comb begin
    state_next     = state;
    data_out       = '0;
    data_out_valid = 1'b1;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    fill_en        = 1'b0;
    word_en        = 1'b0;
    clean_en       = 1'b0;
    case (state)
      DC_IDLE: begin
        if (req) begin
          if (hit) begin
            if (req_wr) word_en  = 1'b1;
            else        data_out = rd_line[int'(offs)*32 +: 32];
          end else begin
            data_out_valid = 1'b0;
            state_next     = (rd_valid && rd_dirty) ? DC_WRITEBACK : DC_REFILL;
          end
        end
      end
      DC_WRITEBACK: begin
        data_out_valid = 1'b0;
        mem_req        = 1'b1;
        mem_we         = 1'b1;
        mem_addr       = {rd_tag, idx, {OFFS_W{1'b0}}};
        mem_wdata      = rd_line;
        if (mem_valid) begin
          clean_en   = 1'b1;
          state_next = DC_REFILL;
        end
      end
      DC_REFILL: begin
        data_out_valid = 1'b0;
        mem_req        = 1'b1;
        mem_addr       = {tag, idx, {OFFS_W{1'b0}}};
        if (mem_valid) begin
          fill_en    = 1'b1;
          state_next = DC_IDLE;
        end
      end
      default: state_next = DC_IDLE;
    endcase
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == DC_IDLE && req) begin
      if (hit) hit_count  <= hit_count + 32'd1;
      else     miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule
